// File: rtl/hsv_threshold.sv
// HSV window thresholding of a byte-serial H,S,V stream with per-frame match counting.

package hsv_threshold_pkg;

    // Active HSV window; a wrapped hue window has h_lo > h_hi
    typedef struct packed {
        logic [7:0] h_lo;
        logic [7:0] h_hi;
        logic [7:0] s_min;
        logic [7:0] v_min;
        logic [7:0] v_max;
    } hsv_win_t;

    localparam hsv_win_t WIN_ALL = '{h_lo: 8'h00, h_hi: 8'hFF, s_min: 8'h00,
                                     v_min: 8'h00, v_max: 8'hFF};

endpackage

module hsv_threshold
    import hsv_threshold_pkg::*;
#(
    parameter int unsigned CNT_W  = 17,
    parameter logic [7:0]  FG_VAL = 8'hFF,
    parameter logic [7:0]  BG_VAL = 8'h00
) (
    input  logic             clk_sys,
    input  logic             reset_sys,
    input  logic             InVSYNC,
    input  logic             InHSYNC,
    input  logic             InEN,
    input  logic [7:0]       InData,
    input  logic [7:0]       CfgHLo,
    input  logic [7:0]       CfgHHi,
    input  logic [7:0]       CfgSMin,
    input  logic [7:0]       CfgVMin,
    input  logic [7:0]       CfgVMax,
    output logic             OutVSYNC,
    output logic             OutHSYNC,
    output logic             OutEN,
    output logic [7:0]       Outdata,
    output logic [CNT_W-1:0] MatchCnt,
    output logic             CntValid,
    output logic             PhaseErr
);

    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        PH_H = 2'd0,
        PH_S = 2'd1,
        PH_V = 2'd2
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [7:0]       h_q, h_d;
    logic [7:0]       s_q, s_d;
    hsv_win_t         win_q, win_d;
    logic             vs_q, vs_d;
    logic             hs_q, hs_d;
    logic             out_en_q, out_en_d;
    logic [7:0]       outdata_q, outdata_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             err_q, err_d;

    logic             hue_ok;
    logic             pix_match;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_sat;

    // Window test for the pixel whose V byte is on InData
    always_comb begin
        hue_ok = 1'b0;
        if (win_q.h_lo <= win_q.h_hi) begin
            hue_ok = (h_q >= win_q.h_lo) && (h_q <= win_q.h_hi);
        end else begin
            hue_ok = (h_q >= win_q.h_lo) || (h_q <= win_q.h_hi);
        end
        pix_match = hue_ok && (s_q >= win_q.s_min)
                    && (InData >= win_q.v_min) && (InData <= win_q.v_max);
    end

    // Saturating accumulate of the registered match pulse
    always_comb begin
        acc_sum = {1'b0, acc_q} + SUM_W'(match_q);
        acc_sat = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    end

    // Next state: byte phase, pixel capture, mask output, config shadow, frame count
    always_comb begin
        phase_d     = phase_q;
        h_d         = h_q;
        s_d         = s_q;
        win_d       = win_q;
        err_d       = err_q;
        out_en_d    = 1'b0;
        outdata_d   = outdata_q;
        match_d     = 1'b0;
        acc_d       = acc_sat;
        cnt_d       = cnt_q;
        cnt_valid_d = InVSYNC;
        vs_d        = InVSYNC;
        hs_d        = InHSYNC;

        // Line start realigns to H; a partial pixel is dropped and flagged
        if (InHSYNC) begin
            phase_d = PH_H;
            if (phase_q != PH_H) begin
                err_d = 1'b1;
            end
        end else if (InEN) begin
            case (phase_q)
                PH_H: begin
                    h_d     = InData;
                    phase_d = PH_S;
                end
                PH_S: begin
                    s_d     = InData;
                    phase_d = PH_V;
                end
                PH_V: begin
                    out_en_d  = 1'b1;
                    match_d   = pix_match;
                    outdata_d = pix_match ? FG_VAL : BG_VAL;
                    phase_d   = PH_H;
                end
                default: phase_d = PH_H;
            endcase
        end

        // Frame boundary: load new window, close the count; a match pulse
        // present in this cycle belongs to the frame being closed
        if (InVSYNC) begin
            win_d = '{h_lo: CfgHLo, h_hi: CfgHHi, s_min: CfgSMin,
                      v_min: CfgVMin, v_max: CfgVMax};
            cnt_d = acc_sat;
            acc_d = '0;
        end
    end

    // Phase state register
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            phase_q <= PH_H;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            h_q         <= '0;
            s_q         <= '0;
            win_q       <= WIN_ALL;
            err_q       <= 1'b0;
            out_en_q    <= 1'b0;
            outdata_q   <= '0;
            match_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cnt_valid_q <= 1'b0;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            s_q         <= s_d;
            win_q       <= win_d;
            err_q       <= err_d;
            out_en_q    <= out_en_d;
            outdata_q   <= outdata_d;
            match_q     <= match_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cnt_valid_q <= cnt_valid_d;
            vs_q        <= vs_d;
            hs_q        <= hs_d;
        end
    end

    assign OutVSYNC = vs_q;
    assign OutHSYNC = hs_q;
    assign OutEN    = out_en_q;
    assign Outdata  = outdata_q;
    assign MatchCnt = cnt_q;
    assign CntValid = cnt_valid_q;
    assign PhaseErr = err_q;

endmodule

// File: tb/tb_hsv_threshold.sv
// Directed bench for hsv_threshold: window tests, wrap, shadowing, full frame, phase error, reset.

module tb_hsv_threshold;

    logic        clk_sys;
    logic        reset_sys;
    logic        InVSYNC, InHSYNC, InEN;
    logic [7:0]  InData;
    logic [7:0]  CfgHLo, CfgHHi, CfgSMin, CfgVMin, CfgVMax;
    logic        OutVSYNC, OutHSYNC, OutEN, CntValid, PhaseErr;
    logic [7:0]  Outdata;
    logic [16:0] MatchCnt;
    logic        s_vs, s_hs, s_en, s_cv, s_pe;
    logic [7:0]  s_data;
    logic [2:0]  s_cnt;

    int errors = 0;
    int checks = 0;
    int oen_cnt;
    int bad_cnt;

    hsv_threshold u_dut (
        .clk_sys(clk_sys), .reset_sys(reset_sys),
        .InVSYNC(InVSYNC), .InHSYNC(InHSYNC), .InEN(InEN), .InData(InData),
        .CfgHLo(CfgHLo), .CfgHHi(CfgHHi), .CfgSMin(CfgSMin),
        .CfgVMin(CfgVMin), .CfgVMax(CfgVMax),
        .OutVSYNC(OutVSYNC), .OutHSYNC(OutHSYNC), .OutEN(OutEN), .Outdata(Outdata),
        .MatchCnt(MatchCnt), .CntValid(CntValid), .PhaseErr(PhaseErr)
    );

    // Narrow-counter copy on the same stream, to reach counter saturation
    hsv_threshold #(.CNT_W(3)) u_small (
        .clk_sys(clk_sys), .reset_sys(reset_sys),
        .InVSYNC(InVSYNC), .InHSYNC(InHSYNC), .InEN(InEN), .InData(InData),
        .CfgHLo(CfgHLo), .CfgHHi(CfgHHi), .CfgSMin(CfgSMin),
        .CfgVMin(CfgVMin), .CfgVMax(CfgVMax),
        .OutVSYNC(s_vs), .OutHSYNC(s_hs), .OutEN(s_en), .Outdata(s_data),
        .MatchCnt(s_cnt), .CntValid(s_cv), .PhaseErr(s_pe)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        InEN   = 1'b1;
        InData = b;
        tick();
        InEN   = 1'b0;
    endtask

    // After return, OutEN/Outdata reflect this pixel
    task automatic pixel(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
        send_byte(h);
        send_byte(s);
        send_byte(v);
    endtask

    task automatic pix_chk(input string tag, input logic [7:0] h, input logic [7:0] s,
                           input logic [7:0] v, input logic [7:0] exp);
        pixel(h, s, v);
        chk({tag, "_en"}, 32'(OutEN), 32'd1);
        chk(tag, 32'(Outdata), 32'(exp));
    endtask

    task automatic sync(input logic vs);
        InVSYNC = vs;
        InHSYNC = 1'b1;
        tick();
        InVSYNC = 1'b0;
        InHSYNC = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] hlo, input logic [7:0] hhi, input logic [7:0] smin,
                           input logic [7:0] vmin, input logic [7:0] vmax);
        CfgHLo  = hlo;
        CfgHHi  = hhi;
        CfgSMin = smin;
        CfgVMin = vmin;
        CfgVMax = vmax;
    endtask

    initial begin
        reset_sys = 1'b0;
        InVSYNC = 1'b0; InHSYNC = 1'b0; InEN = 1'b0; InData = 8'h00;
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        chk("rst_outen", 32'(OutEN), 32'd0);
        chk("rst_outdata", 32'(Outdata), 32'd0);
        chk("rst_matchcnt", 32'(MatchCnt), 32'd0);
        chk("rst_cntvalid", 32'(CntValid), 32'd0);
        chk("rst_phaseerr", 32'(PhaseErr), 32'd0);
        chk("rst_outvsync", 32'(OutVSYNC), 32'd0);
        chk("rst_outhsync", 32'(OutHSYNC), 32'd0);
        reset_sys = 1'b1;
        tick();

        // Default thresholds accept everything
        pix_chk("dflt_a", 8'd100, 8'd0, 8'd0, 8'hFF);
        pix_chk("dflt_b", 8'd255, 8'd0, 8'd255, 8'hFF);

        // Test 1: basic window, latency, hold
        set_cfg(8'd0, 8'd20, 8'd100, 8'd50, 8'd200);
        sync(1'b1);
        chk("t1_outvsync", 32'(OutVSYNC), 32'd1);
        chk("t1_outhsync", 32'(OutHSYNC), 32'd1);
        chk("t1_cntvalid", 32'(CntValid), 32'd1);
        chk("t1_matchcnt", 32'(MatchCnt), 32'd2);
        tick();
        chk("t1_outvsync_off", 32'(OutVSYNC), 32'd0);
        chk("t1_cntvalid_off", 32'(CntValid), 32'd0);
        send_byte(8'd10);
        chk("t1_en_after_h", 32'(OutEN), 32'd0);
        send_byte(8'd200);
        chk("t1_en_after_s", 32'(OutEN), 32'd0);
        send_byte(8'd150);
        chk("t1_en_after_v", 32'(OutEN), 32'd1);
        chk("t1_data", 32'(Outdata), 32'hFF);
        tick();
        chk("t1_en_pulse", 32'(OutEN), 32'd0);
        chk("t1_data_hold", 32'(Outdata), 32'hFF);
        pix_chk("t1_h21", 8'd21, 8'd200, 8'd150, 8'h00);
        pix_chk("t1_edges", 8'd20, 8'd100, 8'd50, 8'hFF);
        pix_chk("t1_s99", 8'd0, 8'd99, 8'd200, 8'h00);
        pix_chk("t1_v201", 8'd0, 8'd255, 8'd201, 8'h00);

        // Test 2: wrapped hue window
        set_cfg(8'd240, 8'd16, 8'd0, 8'd0, 8'd255);
        sync(1'b1);
        chk("t2_matchcnt", 32'(MatchCnt), 32'd2);
        pix_chk("t2_h250", 8'd250, 8'd0, 8'd0, 8'hFF);
        pix_chk("t2_h5", 8'd5, 8'd0, 8'd0, 8'hFF);
        pix_chk("t2_h100", 8'd100, 8'd0, 8'd0, 8'h00);
        pix_chk("t2_h240", 8'd240, 8'd0, 8'd0, 8'hFF);
        pix_chk("t2_h16", 8'd16, 8'd0, 8'd0, 8'hFF);
        pix_chk("t2_h17", 8'd17, 8'd0, 8'd0, 8'h00);
        pix_chk("t2_h239", 8'd239, 8'd0, 8'd0, 8'h00);

        // VMin > VMax never matches
        set_cfg(8'd0, 8'd255, 8'd0, 8'd200, 8'd100);
        sync(1'b1);
        chk("vinv_matchcnt", 32'(MatchCnt), 32'd4);
        pix_chk("vinv_150", 8'd50, 8'd50, 8'd150, 8'h00);
        pix_chk("vinv_100", 8'd50, 8'd50, 8'd100, 8'h00);

        // Test 4: config shadowed until next VSYNC
        set_cfg(8'd0, 8'd20, 8'd100, 8'd50, 8'd200);
        sync(1'b1);
        chk("t4_matchcnt0", 32'(MatchCnt), 32'd0);
        pix_chk("t4_old_a", 8'd10, 8'd200, 8'd150, 8'hFF);
        set_cfg(8'd100, 8'd120, 8'd0, 8'd0, 8'd255);
        pix_chk("t4_old_b", 8'd10, 8'd200, 8'd150, 8'hFF);
        pix_chk("t4_old_c", 8'd110, 8'd0, 8'd0, 8'h00);
        sync(1'b1);
        chk("t4_matchcnt1", 32'(MatchCnt), 32'd2);
        pix_chk("t4_new_a", 8'd10, 8'd200, 8'd150, 8'h00);
        pix_chk("t4_new_b", 8'd110, 8'd0, 8'd0, 8'hFF);

        // Test 3: full 132x200 frame, every 4th pixel matches
        set_cfg(8'd0, 8'd20, 8'd100, 8'd50, 8'd200);
        oen_cnt = 0;
        bad_cnt = 0;
        for (int ln = 0; ln < 200; ln++) begin
            sync(ln == 0);
            if (ln == 0) chk("t3_open_matchcnt", 32'(MatchCnt), 32'd1);
            for (int px = 0; px < 132; px++) begin
                case (px % 4)
                    0:       pixel(8'd100, 8'd200, 8'd150);
                    1:       pixel(8'd10, 8'd50, 8'd150);
                    2:       pixel(8'd10, 8'd200, 8'd250);
                    default: pixel(8'd10, 8'd200, 8'd150);
                endcase
                if (OutEN) oen_cnt++;
                if (Outdata != ((px % 4 == 3) ? 8'hFF : 8'h00)) bad_cnt++;
            end
        end
        tick();
        tick();
        sync(1'b1);
        chk("t3_cntvalid", 32'(CntValid), 32'd1);
        chk("t3_matchcnt", 32'(MatchCnt), 32'd6600);
        chk("t3_small_sat", 32'(s_cnt), 32'd7);
        chk("t3_outen_count", 32'(oen_cnt), 32'd26400);
        chk("t3_outdata_bad", 32'(bad_cnt), 32'd0);

        // Test 5: line ends after two bytes of a pixel
        send_byte(8'd10);
        send_byte(8'd200);
        sync(1'b0);
        chk("t5_outen", 32'(OutEN), 32'd0);
        chk("t5_phaseerr", 32'(PhaseErr), 32'd1);
        chk("t5_outhsync", 32'(OutHSYNC), 32'd1);
        chk("t5_outvsync", 32'(OutVSYNC), 32'd0);
        tick();
        chk("t5_outen_idle", 32'(OutEN), 32'd0);
        pix_chk("t5_next", 8'd10, 8'd200, 8'd150, 8'hFF);
        chk("t5_sticky", 32'(PhaseErr), 32'd1);

        // Test 6: asynchronous reset mid-line
        send_byte(8'd10);
        #2;
        reset_sys = 1'b0;
        #1;
        chk("t6_outdata", 32'(Outdata), 32'd0);
        chk("t6_matchcnt", 32'(MatchCnt), 32'd0);
        chk("t6_phaseerr", 32'(PhaseErr), 32'd0);
        chk("t6_outen", 32'(OutEN), 32'd0);
        tick();
        tick();
        reset_sys = 1'b1;
        tick();
        sync(1'b1);
        chk("t6_cntvalid", 32'(CntValid), 32'd1);
        chk("t6_first_vsync", 32'(MatchCnt), 32'd0);
        pix_chk("t6_decode", 8'd10, 8'd200, 8'd150, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
